// File: rtl/board_pkg.sv
// Shared board geometry, stamper FSM encoding and coordinate wrap/clamp helpers.
// Pure declarations: no latency or flow control of its own.
package board_pkg;
  localparam int MAX_X  = 64;
  localparam int MAX_Y  = 48;
  localparam int PAT_N  = 8;
  localparam int ROW_AW = $clog2(MAX_Y);
  localparam int COL_AW = $clog2(MAX_X);
  localparam int ROW_CW = $clog2(PAT_N);
  localparam int CUR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Base is already clamped, so base + offset stays below 2*MAX and one subtract wraps it.
  function automatic logic [ROW_AW-1:0] wrap_row(input logic [ROW_AW-1:0] base,
                                                 input logic [ROW_CW-1:0] off);
    logic [ROW_AW:0] s;
    s = {1'b0, base} + (ROW_AW+1)'(off);
    if (s >= (ROW_AW+1)'(MAX_Y)) s = s - (ROW_AW+1)'(MAX_Y);
    return s[ROW_AW-1:0];
  endfunction

  function automatic logic [COL_AW-1:0] wrap_col(input logic [COL_AW-1:0] base,
                                                 input logic [ROW_CW-1:0] off);
    logic [COL_AW:0] s;
    s = {1'b0, base} + (COL_AW+1)'(off);
    if (s >= (COL_AW+1)'(MAX_X)) s = s - (COL_AW+1)'(MAX_X);
    return s[COL_AW-1:0];
  endfunction

  function automatic logic [ROW_AW-1:0] clamp_y(input logic [CUR_W-1:0] v);
    return (v >= CUR_W'(MAX_Y)) ? ROW_AW'(MAX_Y - 1) : v[ROW_AW-1:0];
  endfunction

  function automatic logic [COL_AW-1:0] clamp_x(input logic [CUR_W-1:0] v);
    return (v >= CUR_W'(MAX_X)) ? COL_AW'(MAX_X - 1) : v[COL_AW-1:0];
  endfunction
endpackage

// File: rtl/pattern_stamper_if.sv
// Request side and board row port of the pattern stamper.
// slave = the stamper; master = keypad/board-store side.
interface pattern_stamper_if;
  import board_pkg::*;

  logic                     place_req;
  logic [PAT_N*PAT_N-1:0]   pattern_mat;
  logic [CUR_W-1:0]         cursor_x;
  logic [CUR_W-1:0]         cursor_y;
  logic [ROW_AW-1:0]        rd_addr;
  logic [MAX_X-1:0]         rd_data;
  logic                     wr_en;
  logic [ROW_AW-1:0]        wr_addr;
  logic [MAX_X-1:0]         wr_data;
  logic                     busy;
  logic                     done;

  modport master (
    output place_req, pattern_mat, cursor_x, cursor_y, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  place_req, pattern_mat, cursor_x, cursor_y, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/stamp_row_merge.sv
// Combinational: places one pattern row at column cx (wrapping) and merges it into rd_data.
// STAMP_XOR_EN selects XOR (toggle) merge; default is OR (set only). Zero latency, no flow control.
module stamp_row_merge
  import board_pkg::*;
(
  input  logic [PAT_N-1:0]  pat_row,
  input  logic [COL_AW-1:0] cx,
  input  logic [MAX_X-1:0]  rd_data,
  output logic [MAX_X-1:0]  wr_data
);
  logic [MAX_X-1:0] mask;

  always_comb begin
    mask = '0;
    for (int c = 0; c < PAT_N; c++) begin
      if (pat_row[c]) mask[wrap_col(cx, ROW_CW'(c))] = 1'b1;
    end
  end

`ifdef STAMP_XOR_EN
  assign wr_data = rd_data ^ mask;
`else
  assign wr_data = rd_data | mask;
`endif
endmodule

// File: rtl/pattern_stamper.sv
// Stamps a latched 8x8 pattern into the board via 8 read-modify-write rows; 2 cycles/row, done at cycle 17.
// place_req is sampled only in IDLE and never queued; merge mode set by STAMP_XOR_EN.
module pattern_stamper
  import board_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  pattern_stamper_if.slave bus
);
  state_e                 state_q, state_d;
  logic [ROW_CW-1:0]      row_q, row_d;
  logic [ROW_CW-1:0]      row_nxt;
  logic [PAT_N*PAT_N-1:0] pat_q, pat_d;
  logic [COL_AW-1:0]      cx_q, cx_d;
  logic [ROW_AW-1:0]      cy_q, cy_d;
  logic [ROW_AW-1:0]      rd_addr_q, rd_addr_d;
  logic [ROW_AW-1:0]      wr_addr_q, wr_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PAT_N-1:0]       pat_row;
  logic [MAX_X-1:0]       merged;

  assign row_nxt = row_q + 1'b1;
  assign pat_row = pat_q[{row_q, {ROW_CW{1'b0}}} +: PAT_N];

  stamp_row_merge u_merge (
    .pat_row (pat_row),
    .cx      (cx_q),
    .rd_data (bus.rd_data),
    .wr_data (merged)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pat_d     = pat_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.place_req) begin
          pat_d     = bus.pattern_mat;
          cx_d      = clamp_x(bus.cursor_x);
          cy_d      = clamp_y(bus.cursor_y);
          row_d     = '0;
          rd_addr_d = wrap_row(clamp_y(bus.cursor_y), '0);
          busy_d    = 1'b1;
          state_d   = RD;
        end
      end
      RD: begin
        // rd_data for rd_addr_q arrives next cycle, together with the write strobe.
        wr_en_d   = 1'b1;
        wr_addr_d = rd_addr_q;
        state_d   = WR;
      end
      WR: begin
        if (row_q == ROW_CW'(PAT_N - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          row_d     = row_nxt;
          rd_addr_d = wrap_row(cy_q, row_nxt);
          state_d   = RD;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      pat_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_en_q ? merged : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
